// File: rtl/alu_shared_arbiter.sv
// -----------------------------------------------------------------------------
// alu_shared_arbiter
//
// One small ALU (ADD / SUB / AND / OR) shared by two requesters. A
// three-state FSM (IDLE -> EXEC -> HOLD) accepts one operation at a time.
// Simultaneous requests are resolved by a round-robin priority pointer. The
// result is held stable until the consumer accepts it.
//
// Ports
//   clk                  clock; all state updates on the rising edge
//   reset                synchronous, active-high reset
//   req0_valid/req1_valid  requester k presents an operation
//   req0_ready/req1_ready  requester k's operation is accepted this cycle
//                          (combinational, only ever high in IDLE)
//   req0_a/b, req1_a/b   operands, N_BITS wide
//   req0_op/req1_op      opcode: 00 ADD, 01 SUB (a-b), 10 AND, 11 OR
//   res_valid            result available (high only in HOLD)
//   res_ready            consumer accepts the result
//   res_data             result, modulo 2^N_BITS
//   res_id               index of the requester that owns the result
//   res_zero             res_data == 0
//   res_carry            ADD carry out, SUB borrow (a < b unsigned), else 0
// -----------------------------------------------------------------------------
module alu_shared_arbiter #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [N_BITS-1:0] req0_a,
  input  logic [N_BITS-1:0] req0_b,
  input  logic [N_BITS-1:0] req1_a,
  input  logic [N_BITS-1:0] req1_b,
  input  logic [1:0]        req0_op,
  input  logic [1:0]        req1_op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_BITS-1:0] res_data,
  output logic              res_id,
  output logic              res_zero,
  output logic              res_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  state_t              state;
  logic                ptr;        // 0: requester 0 has priority, 1: requester 1
  logic [N_BITS-1:0]   a_q;
  logic [N_BITS-1:0]   b_q;
  logic [1:0]          op_q;
  logic                id_q;

  logic                grant_any;
  logic                grant_id;
  logic [N_BITS:0]     alu_full;   // extra MSB carries the carry/borrow
  logic                alu_carry;

  // Requester 1 wins when it is the only one asking, or when both ask and
  // the pointer favours it. Reset masks the grant so no ready leaks out
  // during a reset cycle.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && !reset) begin
      grant_any = req0_valid | req1_valid;
      grant_id  = req1_valid & (~req0_valid | ptr);
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any &  grant_id;

  // ALU on the latched operands. Zero-extending to N_BITS+1 bits leaves the
  // carry of an add, or the borrow of a subtract, in the top bit.
  always_comb begin
    alu_full  = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_full  = {1'b0, a_q} + {1'b0, b_q};
        alu_carry = alu_full[N_BITS];
      end
      OP_SUB: begin
        alu_full  = {1'b0, a_q} - {1'b0, b_q};
        alu_carry = alu_full[N_BITS];
      end
      OP_AND:  alu_full = {1'b0, a_q & b_q};
      OP_OR:   alu_full = {1'b0, a_q | b_q};
      default: alu_full = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      // NOTE: the operand/opcode latches are not reset; they are always
      // written on a grant before EXEC reads them, so their reset value is
      // never observed.
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_q   <= grant_id ? req1_a  : req0_a;
            b_q   <= grant_id ? req1_b  : req0_b;
            op_q  <= grant_id ? req1_op : req0_op;
            id_q  <= grant_id;
            ptr   <= ~grant_id;        // the loser gets priority next time
            state <= EXEC;
          end
        end

        EXEC: begin
          res_data  <= alu_full[N_BITS-1:0];
          res_zero  <= (alu_full[N_BITS-1:0] == '0);
          res_carry <= alu_carry;
          res_id    <= id_q;
          res_valid <= 1'b1;
          state     <= HOLD;
        end

        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
